// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one burst memory bus between the I-cache and
// the D-cache, holding each grant for the whole burst.
//
// Ports:
//   clk, res                  clock, synchronous active-high reset
//   p0_* / p1_*               cache ports: addr, dataOut, re, we in;
//                             dataIn, ready, grant out
//   mem_addr, mem_dataOut     bus address/write data from the owner
//   mem_re, mem_we            bus strobes from the owner; 0 with no owner
//   mem_dataIn, mem_ready     bus read data and beat completion
//
// Parameters: TAG (debug prefix), IDLE_RELEASE (idle cycles before the
// grant is dropped, 1..15).
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate tie winners;
// otherwise port 1 always wins a tie.

module cache_mem_arbiter #(
    parameter logic [47:0] TAG          = "memArb",
    parameter int          IDLE_RELEASE = 1
) (
    input  logic        clk,
    input  logic        res,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_dataOut,
    input  logic        p0_re,
    input  logic        p0_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_dataOut,
    input  logic        p1_re,
    input  logic        p1_we,
    output logic [31:0] p0_dataIn,
    output logic [31:0] p1_dataIn,
    output logic        p0_ready,
    output logic        p1_ready,
    output logic        p0_grant,
    output logic        p1_grant,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_dataOut,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [31:0] mem_dataIn,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWN0,
        S_OWN1
    } state_t;

    localparam logic [3:0] REL = 4'(IDLE_RELEASE);

    state_t     state, state_nx;
    logic       last_owner, last_owner_nx;
    logic [3:0] idle_cnt, idle_cnt_nx;
    logic       req0, req1;

    // The tag only labels debug output; nothing in hardware consumes it.
    logic unused_tag;
    assign unused_tag = ^TAG;

    assign req0 = p0_re | p0_we;
    assign req1 = p1_re | p1_we;

    always_ff @(posedge clk) begin
        if (res) begin
            state      <= S_IDLE;
            last_owner <= 1'b1;
            idle_cnt   <= 4'd0;
        end else begin
            state      <= state_nx;
            last_owner <= last_owner_nx;
            idle_cnt   <= idle_cnt_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        last_owner_nx = last_owner;
        idle_cnt_nx   = idle_cnt;
        case (state)
            S_IDLE: begin
                idle_cnt_nx = 4'd0;
                if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
                    state_nx = last_owner ? S_OWN0 : S_OWN1;
`else
                    state_nx = S_OWN1;
`endif
                end else if (req0) begin
                    state_nx = S_OWN0;
                end else if (req1) begin
                    state_nx = S_OWN1;
                end
            end
            S_OWN0: begin
                if (req0) begin
                    idle_cnt_nx = 4'd0;
                end else if (idle_cnt + 4'd1 >= REL) begin
                    state_nx      = S_IDLE;
                    last_owner_nx = 1'b0;
                    idle_cnt_nx   = 4'd0;
                end else begin
                    idle_cnt_nx = idle_cnt + 4'd1;
                end
            end
            S_OWN1: begin
                if (req1) begin
                    idle_cnt_nx = 4'd0;
                end else if (idle_cnt + 4'd1 >= REL) begin
                    state_nx      = S_IDLE;
                    last_owner_nx = 1'b1;
                    idle_cnt_nx   = 4'd0;
                end else begin
                    idle_cnt_nx = idle_cnt + 4'd1;
                end
            end
            default: begin
                state_nx    = S_IDLE;
                idle_cnt_nx = 4'd0;
            end
        endcase
    end

    assign p0_grant  = (state == S_OWN0);
    assign p1_grant  = (state == S_OWN1);
    assign p0_dataIn = mem_dataIn;
    assign p1_dataIn = mem_dataIn;

    // Bus mux is driven from the registered owner only; reset silences it
    // immediately so an abandoned burst never issues another strobe.
    always_comb begin
        mem_addr    = 32'd0;
        mem_dataOut = 32'd0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        p0_ready    = 1'b0;
        p1_ready    = 1'b0;
        if (!res) begin
            if (state == S_OWN0) begin
                mem_addr    = p0_addr;
                mem_dataOut = p0_dataOut;
                mem_we      = p0_we;
                mem_re      = p0_re & ~p0_we;
                p0_ready    = mem_ready;
            end else if (state == S_OWN1) begin
                mem_addr    = p1_addr;
                mem_dataOut = p1_dataOut;
                mem_we      = p1_we;
                mem_re      = p1_re & ~p1_we;
                p1_ready    = mem_ready;
            end
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed bench for cache_mem_arbiter with
// IDLE_RELEASE=2; tie expectations follow ARB_ROUND_ROBIN_EN.

module tb_cache_mem_arbiter;

    logic        clk = 1'b0;
    logic        res;
    logic [31:0] p0_addr, p0_dataOut, p1_addr, p1_dataOut;
    logic        p0_re, p0_we, p1_re, p1_we;
    logic [31:0] p0_dataIn, p1_dataIn;
    logic        p0_ready, p1_ready, p0_grant, p1_grant;
    logic [31:0] mem_addr, mem_dataOut, mem_dataIn;
    logic        mem_re, mem_we, mem_ready;

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(
        .TAG          ("memArb"),
        .IDLE_RELEASE (2)
    ) dut (
        .clk         (clk),
        .res         (res),
        .p0_addr     (p0_addr),
        .p0_dataOut  (p0_dataOut),
        .p0_re       (p0_re),
        .p0_we       (p0_we),
        .p1_addr     (p1_addr),
        .p1_dataOut  (p1_dataOut),
        .p1_re       (p1_re),
        .p1_we       (p1_we),
        .p0_dataIn   (p0_dataIn),
        .p1_dataIn   (p1_dataIn),
        .p0_ready    (p0_ready),
        .p1_ready    (p1_ready),
        .p0_grant    (p0_grant),
        .p1_grant    (p1_grant),
        .mem_addr    (mem_addr),
        .mem_dataOut (mem_dataOut),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_dataIn  (mem_dataIn),
        .mem_ready   (mem_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic grants(input string tag, input logic g0, input logic g1);
        chk({tag, "_g0"}, {31'd0, p0_grant}, {31'd0, g0});
        chk({tag, "_g1"}, {31'd0, p1_grant}, {31'd0, g1});
    endtask

    initial begin
        int rdy_cnt;
        int bad;
        logic t1, t2, t3, trst;
`ifdef ARB_ROUND_ROBIN_EN
        t1 = 1'b0; t2 = 1'b0; t3 = 1'b1; trst = 1'b0;
`else
        t1 = 1'b1; t2 = 1'b1; t3 = 1'b1; trst = 1'b1;
`endif
        res = 1'b1;
        p0_addr = 32'h0; p0_dataOut = 32'h0; p0_re = 1'b0; p0_we = 1'b0;
        p1_addr = 32'h0; p1_dataOut = 32'h0; p1_re = 1'b0; p1_we = 1'b0;
        mem_dataIn = 32'h0; mem_ready = 1'b0;
        #2;
        cyc();
        cyc();

        // reset state, with a pending request that must not leak
        p0_re = 1'b1; p0_addr = 32'h1234; mem_ready = 1'b1;
        #1;
        grants("rst", 1'b0, 1'b0);
        chk("rst_mem_re", {31'd0, mem_re}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_dout", mem_dataOut, 32'd0);
        chk("rst_p0_ready", {31'd0, p0_ready}, 32'd0);
        chk("rst_p1_ready", {31'd0, p1_ready}, 32'd0);
        p0_re = 1'b0; mem_ready = 1'b0;

        mem_dataIn = 32'hCAFE_F00D;
        #1;
        chk("bcast_p0", p0_dataIn, 32'hCAFE_F00D);
        chk("bcast_p1", p1_dataIn, 32'hCAFE_F00D);

        // single 256-beat read burst on port 0
        res = 1'b0;
        p0_re = 1'b1; p0_addr = 32'h1000;
        #1;
        chk("lat_g0_pre", {31'd0, p0_grant}, 32'd0);
        chk("lat_bubble", {31'd0, mem_re}, 32'd0);
        cyc();
        chk("lat_g0_post", {31'd0, p0_grant}, 32'd1);
        rdy_cnt = 0;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            p0_addr = 32'h1000 + 32'(i);
            mem_ready = 1'b1;
            #1;
            if (p0_ready === 1'b1) rdy_cnt++;
            if (mem_addr !== p0_addr) bad++;
            if (mem_re !== 1'b1) bad++;
            if (p1_ready !== 1'b0) bad++;
            cyc();
        end
        chk("burst_ready_cnt", 32'(rdy_cnt), 32'd256);
        chk("burst_bad", 32'(bad), 32'd0);
        p0_re = 1'b0; mem_ready = 1'b0;
        cyc();
        grants("rel_hold", 1'b1, 1'b0);
        cyc();
        grants("rel_done", 1'b0, 1'b0);

        // mem_ready with no owner is dropped
        mem_ready = 1'b1;
        #1;
        chk("idle_rdy0", {31'd0, p0_ready}, 32'd0);
        chk("idle_rdy1", {31'd0, p1_ready}, 32'd0);
        mem_ready = 1'b0;

        // tie right after reset, then hand-over to the loser
        res = 1'b1;
        cyc();
        res = 1'b0;
        p0_re = 1'b1; p1_re = 1'b1;
        cyc();
        grants("tie1", ~t1, t1);
        if (t1) p1_re = 1'b0;
        else p0_re = 1'b0;
        cyc();
        grants("tie1_hold", ~t1, t1);
        cyc();
        grants("tie1_rel", 1'b0, 1'b0);
        cyc();
        grants("handover", t1, ~t1);
        p0_re = 1'b0; p1_re = 1'b0;
        cyc();
        cyc();
        grants("handover_rel", 1'b0, 1'b0);

        p0_re = 1'b1; p1_re = 1'b1;
        cyc();
        grants("tie2", ~t2, t2);
        p0_re = 1'b0; p1_re = 1'b0;
        cyc();
        cyc();
        p0_re = 1'b1; p1_re = 1'b1;
        cyc();
        grants("tie3", ~t3, t3);
        p0_re = 1'b0; p1_re = 1'b0;
        cyc();
        cyc();

        // conflicting strobes: write wins
        p0_re = 1'b1; p0_we = 1'b1;
        p0_addr = 32'h2000; p0_dataOut = 32'hDEAD_BEEF;
        cyc();
        chk("conf_we", {31'd0, mem_we}, 32'd1);
        chk("conf_re", {31'd0, mem_re}, 32'd0);
        chk("conf_dout", mem_dataOut, 32'hDEAD_BEEF);
        p0_re = 1'b0; p0_we = 1'b0;
        cyc();
        cyc();

        // writeback, 1-cycle gap, refill, while port 0 waits
        p1_we = 1'b1; p1_addr = 32'h3000; p1_dataOut = 32'h5555_AAAA;
        cyc();
        p0_re = 1'b1; p0_addr = 32'h4000; mem_ready = 1'b1;
        #1;
        grants("wb", 1'b0, 1'b1);
        chk("wb_we", {31'd0, mem_we}, 32'd1);
        chk("wb_re_blocked", {31'd0, mem_re}, 32'd0);
        chk("wb_addr", mem_addr, 32'h3000);
        chk("wb_rdy1", {31'd0, p1_ready}, 32'd1);
        chk("wb_rdy0", {31'd0, p0_ready}, 32'd0);
        cyc();
        cyc();
        cyc();
        p1_we = 1'b0; mem_ready = 1'b0;
        #1;
        chk("gap_we", {31'd0, mem_we}, 32'd0);
        chk("gap_re", {31'd0, mem_re}, 32'd0);
        cyc();
        grants("gap_hold", 1'b0, 1'b1);
        p1_re = 1'b1; p1_addr = 32'h3100;
        #1;
        chk("refill_re", {31'd0, mem_re}, 32'd1);
        chk("refill_addr", mem_addr, 32'h3100);
        cyc();
        cyc();
        grants("refill", 1'b0, 1'b1);
        p1_re = 1'b0;
        cyc();
        grants("refill_idle1", 1'b0, 1'b1);
        cyc();
        grants("refill_idle2", 1'b0, 1'b0);
        cyc();
        grants("p0_after", 1'b1, 1'b0);
        chk("p0_after_addr", mem_addr, 32'h4000);

        // reset in the middle of a port 1 burst
        p0_re = 1'b0;
        cyc();
        cyc();
        p1_re = 1'b1;
        cyc();
        grants("p1_burst", 1'b0, 1'b1);
        p0_re = 1'b1;
        res = 1'b1;
        #1;
        chk("midrst_re_now", {31'd0, mem_re}, 32'd0);
        cyc();
        grants("midrst", 1'b0, 1'b0);
        chk("midrst_re", {31'd0, mem_re}, 32'd0);
        chk("midrst_we", {31'd0, mem_we}, 32'd0);
        res = 1'b0;
        cyc();
        grants("tie_after_rst", ~trst, trst);
        p0_re = 1'b0; p1_re = 1'b0;
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
